// File: rtl/galaxian_dl_ctrl_if.sv
// ROM download bus between data_io (master) and galaxian_dl_ctrl (slave):
// the ioctl-side write stream plus the registered, region-decoded write port.
interface galaxian_dl_ctrl_if;
    logic        dl_active_i;
    logic [7:0]  dl_index_i;
    logic        dl_wr_i;
    logic [24:0] dl_addr_i;
    logic [7:0]  dl_data_i;
    logic [15:0] rom_addr_o;
    logic [7:0]  rom_data_o;
    logic        pgm_we_o;
    logic        gfx1k_we_o;
    logic        gfx1h_we_o;
    logic        prom_we_o;

    modport master (
        output dl_active_i, dl_index_i, dl_wr_i, dl_addr_i, dl_data_i,
        input  rom_addr_o, rom_data_o, pgm_we_o, gfx1k_we_o, gfx1h_we_o, prom_we_o
    );

    modport slave (
        input  dl_active_i, dl_index_i, dl_wr_i, dl_addr_i, dl_data_i,
        output rom_addr_o, rom_data_o, pgm_we_o, gfx1k_we_o, gfx1h_we_o, prom_we_o
    );
endinterface

// File: rtl/galaxian_dl_ctrl.sv
// Galaxian ROM download front end: region write strobes, core reset sequencing, status.
// Optional DL_CHECKSUM_EN adds a 16-bit byte sum (dl_sum_o) checked against EXPECT_SUM.
module galaxian_dl_ctrl #(
    parameter logic [7:0]  ROM_INDEX    = 8'd0,
    parameter logic [16:0] EXPECT_BYTES = 17'h6020,
    parameter int unsigned HOLD_CYCLES  = 1024
`ifdef DL_CHECKSUM_EN
    ,
    parameter logic [15:0] EXPECT_SUM   = 16'h0000
`endif
) (
    input  logic              clk_sys,
    input  logic              res_n_i,
    galaxian_dl_ctrl_if.slave dl_if,
    output logic              core_reset_o,
    output logic              dl_done_o,
    output logic              dl_err_o,
    output logic [16:0]       dl_count_o
`ifdef DL_CHECKSUM_EN
    ,
    output logic [15:0]       dl_sum_o
`endif
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

    state_t        state_q, state_d;
    logic          active_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    we_q, we_d;
    logic          core_rst_q, core_rst_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [16:0]   cnt_q, cnt_d;
    logic          match, rise, fall, sum_bad;
`ifdef DL_CHECKSUM_EN
    logic [15:0]   sum_q, sum_d;
`endif

    function automatic logic [16:0] sat_inc(input logic [16:0] v);
        return (v == 17'h1FFFF) ? v : v + 17'd1;
    endfunction

    // One-hot {prom, 1H, 1K, pgm}; zero means the address is outside the image.
    function automatic logic [3:0] region(input logic [24:0] a);
        if (a < 25'h4000)      return 4'b0001;
        else if (a < 25'h5000) return 4'b0010;
        else if (a < 25'h6000) return 4'b0100;
        else if (a < 25'h6020) return 4'b1000;
        else                   return 4'b0000;
    endfunction

    assign match = (dl_if.dl_index_i == ROM_INDEX);
    assign rise  = match & dl_if.dl_active_i & ~active_q;
    assign fall  = ~dl_if.dl_active_i & active_q;

`ifdef DL_CHECKSUM_EN
    assign sum_bad = (EXPECT_SUM != 16'h0000) && (sum_q != EXPECT_SUM);
`else
    assign sum_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 4'b0000;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef DL_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (rise && state_q != S_LOAD) begin
            state_d = S_LOAD;
            hold_d  = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
`ifdef DL_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (dl_if.dl_wr_i && match) begin
                        addr_d = dl_if.dl_addr_i[15:0];
                        data_d = dl_if.dl_data_i;
                        we_d   = region(dl_if.dl_addr_i);
                        if (we_d != 4'b0000) begin
                            cnt_d = sat_inc(cnt_q);
`ifdef DL_CHECKSUM_EN
                            sum_d = sum_q + {8'h00, dl_if.dl_data_i};
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    // The count check must include a write landing on the falling cycle.
                    if (fall) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                        if (cnt_d != EXPECT_BYTES) err_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        if (err_q || sum_bad) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        core_rst_d = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
    end

    // Edge-detect copy resets high so a download already active at release is not taken.
    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            state_q    <= S_IDLE;
            active_q   <= 1'b1;
            hold_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
`ifdef DL_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            active_q   <= dl_if.dl_active_i;
            hold_q     <= hold_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`ifdef DL_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign dl_if.rom_addr_o   = addr_q;
    assign dl_if.rom_data_o   = data_q;
    assign dl_if.pgm_we_o     = we_q[0];
    assign dl_if.gfx1k_we_o   = we_q[1];
    assign dl_if.gfx1h_we_o   = we_q[2];
    assign dl_if.prom_we_o    = we_q[3];
    assign core_reset_o       = core_rst_q;
    assign dl_done_o          = done_q;
    assign dl_err_o           = err_q;
    assign dl_count_o         = cnt_q;
`ifdef DL_CHECKSUM_EN
    assign dl_sum_o           = sum_q;
`endif

endmodule

// File: tb/tb_galaxian_dl_ctrl.sv
// Directed bench for galaxian_dl_ctrl: full/short/bad images, foreign index, restart and reset.
// Build with DL_CHECKSUM_EN defined to also exercise the checksum gate.
module tb_galaxian_dl_ctrl;
    localparam int H = 16;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        core_reset, done, err;
    logic [16:0] count;
`ifdef DL_CHECKSUM_EN
    logic [15:0] sum;
    logic [15:0] sum_m;
`endif

    int checks = 0, failures = 0;
    int n_pgm = 0, n_1k = 0, n_1h = 0, n_prom = 0, n_multi = 0, n_rsthi = 0;
    int s_pgm, s_1k, s_1h, s_prom, s_rsthi, n;

    galaxian_dl_ctrl_if dl_if ();

    galaxian_dl_ctrl #(
        .HOLD_CYCLES (H)
`ifdef DL_CHECKSUM_EN
        ,
        .EXPECT_SUM  (16'hD5F0)
`endif
    ) dut (
        .clk_sys      (clk),
        .res_n_i      (res_n),
        .dl_if        (dl_if),
        .core_reset_o (core_reset),
        .dl_done_o    (done),
        .dl_err_o     (err),
        .dl_count_o   (count)
`ifdef DL_CHECKSUM_EN
        ,
        .dl_sum_o     (sum)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dl_if.pgm_we_o)   n_pgm++;
        if (dl_if.gfx1k_we_o) n_1k++;
        if (dl_if.gfx1h_we_o) n_1h++;
        if (dl_if.prom_we_o)  n_prom++;
        if (32'(dl_if.pgm_we_o) + 32'(dl_if.gfx1k_we_o) + 32'(dl_if.gfx1h_we_o)
            + 32'(dl_if.prom_we_o) > 1) n_multi++;
        if (core_reset) n_rsthi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ v[15:8] ^ 8'h5A;
    endfunction

    task automatic snap();
        s_pgm = n_pgm; s_1k = n_1k; s_1h = n_1h; s_prom = n_prom; s_rsthi = n_rsthi;
    endtask

    task automatic dl_start(input logic [7:0] idx);
        dl_if.dl_index_i  = idx;
        dl_if.dl_active_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic dl_byte(input int a, input logic [7:0] d);
        dl_if.dl_wr_i   = 1'b1;
        dl_if.dl_addr_i = 25'(a);
        dl_if.dl_data_i = d;
        @(posedge clk); #1;
        dl_if.dl_wr_i   = 1'b0;
    endtask

    // Drop dl_active_i, optionally with a write in that same cycle; returns after the fall is registered.
    task automatic dl_finish(input bit wr, input int a, input logic [7:0] d);
        dl_if.dl_active_i = 1'b0;
        dl_if.dl_wr_i     = wr;
        dl_if.dl_addr_i   = 25'(a);
        dl_if.dl_data_i   = d;
        @(posedge clk); #1;
        dl_if.dl_wr_i     = 1'b0;
    endtask

    task automatic stream(input int lo, input int hi, input int flip_at);
        for (int a = lo; a < hi; a++) dl_byte(a, (a == flip_at) ? ~dat(a) : dat(a));
    endtask

    task automatic wait_run(output int cyc);
        cyc = 0;
        while (cyc < 4 * H) begin
            @(posedge clk); #1;
            cyc++;
            if (!core_reset) break;
        end
    endtask

    initial begin
        dl_if.dl_active_i = 1'b0;
        dl_if.dl_index_i  = 8'd0;
        dl_if.dl_wr_i     = 1'b0;
        dl_if.dl_addr_i   = '0;
        dl_if.dl_data_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rom_addr", 32'(dl_if.rom_addr_o), 32'd0);
        check("rst_strobes", {28'd0, dl_if.prom_we_o, dl_if.gfx1h_we_o, dl_if.gfx1k_we_o,
                              dl_if.pgm_we_o}, 32'd0);
        @(negedge clk); res_n = 1'b1;
        @(posedge clk); #1;

        // Reset asserted mid-LOAD
        dl_start(8'd0);
        stream(0, 100, -1);
        check("midload_count", 32'(count), 32'd100);
        check("midload_pgm_we", 32'(dl_if.pgm_we_o), 32'd1);
        dl_if.dl_wr_i = 1'b1;
        res_n = 1'b0;
        #1;
        check("arst_pgm_we", 32'(dl_if.pgm_we_o), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        #2 res_n = 1'b1;
        snap();
        stream(100, 110, -1);
        check("postrst_no_strobe", 32'(n_pgm - s_pgm), 32'd0);
        check("postrst_count", 32'(count), 32'd0);
        dl_finish(1'b0, 0, 8'h00);
        repeat (3) @(posedge clk);
        #1;

        // Short download, then restart while holding
        dl_start(8'd0);
        stream(0, 16, -1);
        dl_finish(1'b0, 0, 8'h00);
        check("hold_short_err", 32'(err), 32'd1);
        repeat (H / 2) @(posedge clk);
        #1;
        check("hold_core_reset", 32'(core_reset), 32'd1);
        dl_start(8'd0);
        check("restart_count", 32'(count), 32'd0);
        check("restart_err", 32'(err), 32'd0);

        // Full image; last byte written in the cycle dl_active_i falls
        snap();
        stream(0, 16'h4123, -1);
        dl_byte(16'h4123, 8'hA5);
        check("wr_rom_addr", 32'(dl_if.rom_addr_o), 32'h4123);
        check("wr_rom_data", 32'(dl_if.rom_data_o), 32'hA5);
        check("wr_1k_we", 32'(dl_if.gfx1k_we_o), 32'd1);
        stream(16'h4124, 16'h601F, -1);
        dl_finish(1'b1, 16'h601F, dat(16'h601F));
        check("full_count", 32'(count), 32'h6020);
        check("full_err", 32'(err), 32'd0);
        wait_run(n);
        check("full_hold_cycles", 32'(n), 32'(H));
        check("full_n_pgm", 32'(n_pgm - s_pgm), 32'h4000);
        check("full_n_1k", 32'(n_1k - s_1k), 32'h1000);
        check("full_n_1h", 32'(n_1h - s_1h), 32'h1000);
        check("full_n_prom", 32'(n_prom - s_prom), 32'h20);
        check("full_multi", 32'(n_multi), 32'd0);
        check("full_done", 32'(done), 32'd1);
`ifdef DL_CHECKSUM_EN
        check("full_sum", 32'(sum), 32'hD5F0);
`endif

        // Foreign-index download while running
        snap();
        dl_start(8'd1);
        stream(0, 100, -1);
        dl_finish(1'b0, 0, 8'h00);
        repeat (H + 4) @(posedge clk);
        #1;
        check("idx1_strobes", 32'((n_pgm - s_pgm) + (n_1k - s_1k) + (n_1h - s_1h) + (n_prom - s_prom)), 32'd0);
        check("idx1_count", 32'(count), 32'h6020);
        check("idx1_done", 32'(done), 32'd1);
        check("idx1_core_reset_hi", 32'(n_rsthi - s_rsthi), 32'd0);

        // Full image plus one write at 0x7000
        snap();
        dl_start(8'd0);
        stream(0, 16'h3000, -1);
        dl_byte(32'h7000, 8'h33);
        check("oor_strobes", {28'd0, dl_if.prom_we_o, dl_if.gfx1h_we_o, dl_if.gfx1k_we_o,
                              dl_if.pgm_we_o}, 32'd0);
        check("oor_err_now", 32'(err), 32'd1);
        check("oor_core_reset", 32'(core_reset), 32'd1);
        stream(16'h3000, 16'h6020, -1);
        dl_finish(1'b0, 0, 8'h00);
        check("oor_count", 32'(count), 32'h6020);
        check("oor_total", 32'((n_pgm - s_pgm) + (n_1k - s_1k) + (n_1h - s_1h) + (n_prom - s_prom)), 32'h6020);
        repeat (H + 4) @(posedge clk);
        #1;
        check("oor_err", 32'(err), 32'd1);
        check("oor_stays_reset", 32'(core_reset), 32'd1);
        check("oor_done", 32'(done), 32'd0);

`ifdef DL_CHECKSUM_EN
        // Full image with one byte corrupted
        dl_start(8'd0);
        stream(0, 16'h6020, 16'h1234);
        dl_finish(1'b0, 0, 8'h00);
        check("cks_count_err", 32'(err), 32'd0);
        sum_m = 16'hD5F0 - {8'h00, dat(16'h1234)} + {8'h00, ~dat(16'h1234)};
        check("cks_sum", 32'(sum), 32'(sum_m));
        repeat (H + 4) @(posedge clk);
        #1;
        check("cks_err", 32'(err), 32'd1);
        check("cks_stays_reset", 32'(core_reset), 32'd1);
`else
        // Short image
        dl_start(8'd0);
        stream(0, 16'h5000, -1);
        dl_finish(1'b0, 0, 8'h00);
        check("short_count", 32'(count), 32'h5000);
        check("short_err", 32'(err), 32'd1);
        repeat (H + 4) @(posedge clk);
        #1;
        check("short_stays_reset", 32'(core_reset), 32'd1);
        check("short_done", 32'(done), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
